// File: rtl/test_pattern_sequencer.sv
// Purpose: frame-synchronous scheduler choosing one of four test patterns for the RGB guns.
// Latency: rgb is registered 1 clk after hpos/vpos/display_on; pattern switches only at frame_start.
// Backpressure: none; consumes the beam timing every clock and never stalls.
//
// Ports:
//   clk, reset            pixel clock; asynchronous active-high reset
//   hpos, vpos            beam position from hvsync_generator
//   display_on, vsync     visible-region flag and vertical sync (active-high)
//   btn_next, btn_hold    asynchronous buttons: step pattern / toggle AUTO-HOLD
//   rgb                   registered {r,g,b} drive, forced to 0 outside the visible region
//   pattern               currently displayed pattern (0 bars, 1 checker, 2 grid, 3 ramp)
//   hold                  1 = HOLD (no automatic advance), 0 = AUTO
module test_pattern_sequencer #(
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       display_on,
    input  logic       vsync,
    input  logic       btn_next,
    input  logic       btn_hold,
    output logic [2:0] rgb,
    output logic [1:0] pattern,
    output logic       hold
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);

    typedef enum logic {
        MODE_AUTO = 1'b0,
        MODE_HOLD = 1'b1
    } mode_t;

    mode_t      mode_q;
    mode_t      mode_d;
    logic [2:0] next_sync;
    logic [2:0] hold_sync;
    logic       next_edge;
    logic       hold_edge;
    logic       vsync_d;
    logic       frame_start;
    logic [7:0] frame_cnt;
    logic       pending;
    logic       auto_adv;
    logic       advance;
    logic [2:0] pix;

    // Bit 8 of the beam position never affects any pattern.
    logic unused_pos_bits;
    assign unused_pos_bits = ^{hpos[8], vpos[8]};

    // Two synchronizer stages plus a history stage per button; [0] is the
    // first stage, so an edge pulse appears 2 clks after the input rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_sync <= 3'b000;
            hold_sync <= 3'b000;
            vsync_d   <= 1'b0;
        end else begin
            next_sync <= {next_sync[1:0], btn_next};
            hold_sync <= {hold_sync[1:0], btn_hold};
            vsync_d   <= vsync;
        end
    end

    assign next_edge   = next_sync[1] & ~next_sync[2];
    assign hold_edge   = hold_sync[1] & ~hold_sync[2];
    assign frame_start = vsync & ~vsync_d;

    // Mode FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_AUTO;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state. A hold edge toggles regardless of frame timing.
    always_comb begin
        mode_d = mode_q;
        if (hold_edge) begin
            mode_d = (mode_q == MODE_AUTO) ? MODE_HOLD : MODE_AUTO;
        end
    end

    // Mode FSM: outputs.
    always_comb begin
        hold = (mode_q == MODE_HOLD);
    end

    // The auto step is decided in the boundary cycle itself so it lands on
    // the same edge as a manual step; OR-ing them guarantees a single step.
    assign auto_adv = (mode_q == MODE_AUTO) && frame_start && (frame_cnt == CNT_LAST);
    assign advance  = frame_start && (auto_adv || pending || next_edge);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (mode_q == MODE_HOLD) begin
            // Counter is frozen in HOLD; leaving HOLD restarts the count.
            if (hold_edge) begin
                frame_cnt <= 8'd0;
            end
        end else if (frame_start) begin
            // A hold edge on this boundary still lets the count update.
            frame_cnt <= (frame_cnt == CNT_LAST) ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    // A request arriving on the boundary itself is consumed there, so the
    // boundary clear has priority over the set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (frame_start) begin
            pending <= 1'b0;
        end else if (next_edge) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= 2'd0;
        end else if (advance) begin
            pattern <= pattern + 2'd1;
        end
    end

    always_comb begin
        pix = 3'b000;
        case (pattern)
            2'd0:    pix = {~hpos[6], ~hpos[7], ~hpos[5]};
            2'd1:    pix = {3{hpos[4] ^ vpos[4]}};
            2'd2:    pix = ((hpos[3:0] == 4'd0) || (vpos[3:0] == 4'd0)) ? 3'b111 : 3'b000;
            default: pix = vpos[7:5];
        endcase
        if (!display_on) begin
            pix = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= 3'b000;
        end else begin
            rgb <= pix;
        end
    end

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Purpose: self-checking bench for test_pattern_sequencer (directed scenarios plus random frames).
// Latency: reference model predicts outputs one clock after each input vector.
// Backpressure: not applicable; stimulus is free-running beam timing and buttons.
module tb_test_pattern_sequencer;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] hpos = '0;
    logic [8:0] vpos = '0;
    logic       display_on = 1'b0;
    logic       vsync = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_hold = 1'b0;
    logic [2:0] rgb;
    logic [1:0] pattern;
    logic       hold;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_pat, m_cnt, m_rgb;
    bit m_hold, m_pend, vs_prev;
    bit bn_hist[3];   // bn_hist[k] = btn_next level k+1 cycles ago
    bit bh_hist[3];
    int bn_cnt, bh_cnt;

    test_pattern_sequencer #(.FRAMES_PER_PATTERN(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .vsync      (vsync),
        .btn_next   (btn_next),
        .btn_hold   (btn_hold),
        .rgb        (rgb),
        .pattern    (pattern),
        .hold       (hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pix(input int p, input int h, input int v, input bit de);
        if (!de) return 0;
        case (p)
            0:       return ((((h >> 6) & 1) ^ 1) << 2) | ((((h >> 7) & 1) ^ 1) << 1) | (((h >> 5) & 1) ^ 1);
            1:       return (((h >> 4) ^ (v >> 4)) & 1) != 0 ? 7 : 0;
            2:       return ((h % 16 == 0) || (v % 16 == 0)) ? 7 : 0;
            default: return (v >> 5) & 7;
        endcase
    endfunction

    task automatic model_reset();
        m_pat = 0; m_cnt = 0; m_rgb = 0;
        m_hold = 0; m_pend = 0; vs_prev = 0;
        for (int k = 0; k < 3; k++) begin
            bn_hist[k] = 0;
            bh_hist[k] = 0;
        end
        bn_cnt = 0; bh_cnt = 0;
    endtask

    // One clock: apply inputs, advance the model, compare all outputs.
    task automatic cyc(input int h, input int v, input bit de, input bit vs, input bit bn, input bit bh);
        bit en, eh, fs, adv;
        int n_pat, n_cnt;
        bit n_hold, n_pend;
        @(negedge clk);
        hpos = h[8:0]; vpos = v[8:0]; display_on = de;
        vsync = vs; btn_next = bn; btn_hold = bh;
        en = bn_hist[1] & ~bn_hist[2];
        eh = bh_hist[1] & ~bh_hist[2];
        fs = vs & ~vs_prev;
        adv = fs && ((!m_hold && m_cnt == N - 1) || m_pend || en);
        n_pat = adv ? (m_pat + 1) % 4 : m_pat;
        n_pend = fs ? 1'b0 : (en ? 1'b1 : m_pend);
        n_cnt = m_cnt;
        if (m_hold) begin
            if (eh) n_cnt = 0;
        end else if (fs) begin
            n_cnt = (m_cnt == N - 1) ? 0 : m_cnt + 1;
        end
        n_hold = eh ? !m_hold : m_hold;
        m_rgb = pix(m_pat, h, v, de);
        m_pat = n_pat; m_cnt = n_cnt; m_hold = n_hold; m_pend = n_pend;
        bn_hist[2] = bn_hist[1]; bn_hist[1] = bn_hist[0]; bn_hist[0] = bn;
        bh_hist[2] = bh_hist[1]; bh_hist[1] = bh_hist[0]; bh_hist[0] = bh;
        vs_prev = vs;
        @(posedge clk);
        #1;
        chk("rgb", 32'(rgb), 32'(m_rgb));
        chk("pattern", 32'(pattern), 32'(m_pat));
        chk("hold", 32'(hold), 32'(m_hold));
    endtask

    // vs_len cycles of vsync at the start; vs_len=0 gives idle cycles.
    // A button index starts a 3-cycle press; -1 means no press.
    task automatic frame(input int len, input int vs_len, input int bn_at, input int bh_at);
        for (int i = 0; i < len; i++) begin
            if (i == bn_at) bn_cnt = 3;
            if (i == bh_at) bh_cnt = 3;
            cyc(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                1'($urandom_range(0, 1)), i < vs_len, bn_cnt > 0, bh_cnt > 0);
            if (bn_cnt > 0) bn_cnt--;
            if (bh_cnt > 0) bh_cnt--;
        end
    endtask

    task automatic std_frame();
        frame(16, 2, -1, -1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vsync = 0; btn_next = 0; btn_hold = 0; display_on = 0;
        repeat (2) @(negedge clk);
        chk("reset_rgb", 32'(rgb), 0);
        chk("reset_pattern", 32'(pattern), 0);
        chk("reset_hold", 32'(hold), 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int seq[5];
        int len;
        seq = '{0, 0, 1, 1, 2};
        model_reset();
        do_reset();

        // Bars and blanking on pattern 0.
        cyc(0, 0, 1, 0, 0, 0);
        chk("bars_h000", 32'(rgb), 7);
        cyc('h0E0, 0, 1, 0, 0, 0);
        chk("bars_h0e0", 32'(rgb), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("blank", 32'(rgb), 0);

        // AUTO with N=2: pattern observed before each vsync pulse.
        for (int k = 0; k < 5; k++) begin
            chk("auto_seq", 32'(pattern), 32'(seq[k]));
            std_frame();
        end
        chk("auto_hold", 32'(hold), 0);

        // Enter HOLD; pattern frozen over 10 frames.
        frame(6, 0, -1, 0);
        chk("hold_on", 32'(hold), 1);
        for (int k = 0; k < 10; k++) std_frame();
        chk("hold_frozen", 32'(pattern), 2);

        // Two next presses in one frame give one step, only at the boundary.
        frame(6, 0, 0, -1);
        frame(6, 0, 0, -1);
        chk("next_wait", 32'(pattern), 2);
        std_frame();
        chk("next_once", 32'(pattern), 3);
        std_frame();
        chk("next_no_more", 32'(pattern), 3);

        // Wrap 3 -> 0, then walk to the grid pattern.
        frame(6, 0, 0, -1); std_frame();
        chk("wrap", 32'(pattern), 0);
        frame(6, 0, 0, -1); std_frame();
        frame(6, 0, 0, -1); std_frame();
        chk("to_grid", 32'(pattern), 2);
        cyc('h010, 'h005, 1, 0, 0, 0);
        chk("grid_line", 32'(rgb), 7);
        cyc('h011, 'h005, 1, 0, 0, 0);
        chk("grid_off", 32'(rgb), 0);

        // Back to AUTO (count restarts); auto and manual on the same boundary.
        frame(6, 0, -1, 0);
        chk("auto_again", 32'(hold), 0);
        std_frame();
        chk("auto_cnt1", 32'(pattern), 2);
        frame(6, 0, 0, -1);
        std_frame();
        chk("auto_plus_next", 32'(pattern), 3);
        std_frame();
        chk("pending_cleared", 32'(pattern), 3);
        std_frame();
        chk("auto_step", 32'(pattern), 0);

        // Next edge coinciding with frame_start (and with an auto step).
        frame(16, 2, 14, -1);
        chk("coinc_pre", 32'(pattern), 0);
        std_frame();
        chk("coinc_step", 32'(pattern), 1);
        std_frame();
        chk("coinc_after", 32'(pattern), 1);

        // Hold edge coinciding with frame_start in AUTO.
        frame(16, 2, -1, 14);
        chk("hcoinc_pre", 32'(pattern), 2);
        std_frame();
        chk("hcoinc_hold", 32'(hold), 1);
        chk("hcoinc_pat", 32'(pattern), 2);
        std_frame();
        chk("hcoinc_frozen", 32'(pattern), 2);

        // Random frames, buttons at random phases; long vsync pulses included.
        for (int k = 0; k < 40; k++) begin
            int bn_at, bh_at;
            len = int'($urandom_range(10, 24));
            bn_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, len - 1));
            bh_at = ($urandom_range(0, 3) != 0) ? -1 : int'($urandom_range(0, len - 1));
            frame(len, int'($urandom_range(1, 6)), bn_at, bh_at);
        end

        // Asynchronous reset mid-line in HOLD with pattern 2 and a pending step.
        do_reset();
        frame(6, 0, -1, 0);
        frame(6, 0, 0, -1); std_frame();
        frame(6, 0, 0, -1); std_frame();
        chk("pre_rst_pat", 32'(pattern), 2);
        frame(6, 0, 0, -1);
        cyc(0, 0, 1, 0, 0, 0);
        chk("pre_rst_rgb", 32'(rgb), 7);
        chk("pre_rst_hold", 32'(hold), 1);
        #2;
        reset = 1'b1;
        vsync = 0; btn_next = 0; btn_hold = 0;
        #1;
        chk("arst_rgb", 32'(rgb), 0);
        chk("arst_pattern", 32'(pattern), 0);
        chk("arst_hold", 32'(hold), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        std_frame();
        chk("post_rst_pat", 32'(pattern), 0);
        chk("post_rst_hold", 32'(hold), 0);
        std_frame();
        chk("post_rst_step", 32'(pattern), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/test_pattern_sequencer.md
# test_pattern_sequencer

Frame-synchronous controller that schedules which test pattern drives the RGB guns. It sits between `hvsync_generator` and the video output, consuming `hpos`, `vpos`, `display_on` and `vsync`. It selects one of four patterns (SMPTE-style bars, checkerboard, grid, row colour ramp). Patterns advance automatically every N frames or manually from a button, and only ever switch at a frame boundary.

## Interface
- `FRAMES_PER_PATTERN`, default 120: frames each pattern is shown in AUTO mode; legal range 1..255.
- `clk`  input  1  pixel clock, shared with `hvsync_generator`.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `hpos`  input  9  horizontal beam position.
- `vpos`  input  9  vertical beam position.
- `display_on`  input  1  visible-region flag.
- `vsync`  input  1  vertical sync, active-high.
- `btn_next`  input  1  asynchronous push button; request next pattern.
- `btn_hold`  input  1  asynchronous push button; toggle AUTO/HOLD.
- `rgb`  output  3  {r,g,b} gun drive, registered.
- `pattern`  output  2  currently displayed pattern index.
- `hold`  output  1  1 = HOLD mode, 0 = AUTO mode.

## Operation
- Button inputs: each passes through a 2-flop synchronizer plus a third history flop. Rising edge = sync2 & ~sync3, a 1-cycle pulse. No debounce; the bench drives clean levels.
- Frame boundary: `vsync_d` registers `vsync`; `frame_start` = `vsync & ~vsync_d`, a 1-cycle internal pulse.
- Mode state machine, two states:
  - AUTO (reset state).
  - HOLD.
  - A `btn_hold` edge toggles the state immediately, i.e. on the cycle after the edge pulse.
  - Entering AUTO clears `frame_cnt` to 0.
- Frame counter `frame_cnt` (8 bits):
  - In AUTO, at each `frame_start`: if `frame_cnt == FRAMES_PER_PATTERN-1`, set `auto_adv` and clear to 0; otherwise increment.
  - In HOLD, `frame_cnt` is frozen.
- Manual request: a `btn_next` edge sets `pending`. It is applied and cleared only at `frame_start`. Extra edges while `pending` is set are absorbed, so at most one step per frame.
- Pattern update:
  - At `frame_start`, if (`auto_adv` or `pending`), `pattern` increments by exactly 1, wrapping 3->0.
  - Simultaneous auto and manual advance gives one step, not two.
  - `pattern` never changes outside a `frame_start` cycle.
- Pixel generation (combinational from inputs, then registered into `rgb`):
  - 0 bars: {~hpos[6], ~hpos[7], ~hpos[5]}.
  - 1 checker: all three bits = hpos[4]^vpos[4].
  - 2 grid: 3'b111 if hpos[3:0]==0 or vpos[3:0]==0, else 3'b000.
  - 3 ramp: vpos[7:5].
  - Any pattern: `rgb` forced to 3'b000 when `display_on`==0.
- Reset mid-frame: all state returns to reset values asynchronously. The first `frame_start` after release counts as frame 0 and advances nothing unless `FRAMES_PER_PATTERN`==1.

## Timing
- Reset values: `rgb`=0, `pattern`=0, `hold`=0, `frame_cnt`=0, `pending`=0, `vsync_d`=0, all synchronizer flops 0.
- `rgb` latency: 1 clk from `hpos`/`vpos`/`display_on`.
- `frame_start` is asserted in the cycle `vsync` is first seen high. `pattern` takes its new value on the next edge, which is the first cycle `vsync_d`=1.
- Button to internal edge pulse: 2 clks after the input rises. `hold` toggles 3 clks after the `btn_hold` rise.
- A `btn_next` edge landing in the same cycle as `frame_start`:
  - It is applied at that same boundary, i.e. `pending` is treated as set.
  - `pending` ends at 0.
- A `btn_hold` edge in the same cycle as `frame_start` in AUTO:
  - The frame counter update for that boundary still happens.
  - The mode toggles to HOLD at that edge.
- `vsync` held high for many cycles produces a single `frame_start`.

## Test plan
- Reset with `FRAMES_PER_PATTERN`=2, then pulse `vsync` for 5 frames with no buttons -> `pattern` sequence 0,0,1,1,2 (changes after frames 2 and 4); `hold`=0.
- Pattern 0, `display_on`=1, hpos=0x000 -> `rgb`=3'b111 one clk later. hpos=0x0E0 -> 3'b000. With `display_on`=0 at hpos=0 -> 3'b000.
- Press `btn_hold`, then run 10 frames -> `pattern` unchanged, `hold`=1. Pulse `btn_next` twice within one frame -> `pattern` +1 exactly once, at the next `frame_start` only.
- AUTO with `frame_cnt`=1 (N=2) plus a `btn_next` edge in the same frame -> a single increment at the boundary, `pending`=0, `frame_cnt`=0.
- `pattern`=3 plus a manual advance -> wraps to 0. Check the pattern 2 grid: hpos=0x010, vpos=0x005 -> `rgb`=3'b111; hpos=0x011, vpos=0x005 -> 3'b000.
- Assert `reset` mid-line while in HOLD with `pattern`=2 and `pending`=1 -> outputs are 0 immediately (asynchronous). After release, `hold`=0, `pattern`=0, and no spurious advance on the first `frame_start` with N=2.
